// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the next-PC select codes and the bit positions of the func and
// ins_type fields inside an instruction word.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    // Fetch FSM: waiting for a fetch strobe, or holding a memory request open.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    // Next-PC select codes driven by the stage sequencer.
    localparam logic [1:0] PC_SEL_INC    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_RET    = 2'b11;

    // Instruction field positions.
    localparam int FUNC_MSB = 31;
    localparam int FUNC_LSB = 27;
    localparam int TYPE_MSB = 2;
    localparam int TYPE_LSB = 1;

endpackage

// File: rtl/fetch_unit_next_pc_mux.sv
// ---------------------------------------------------------------------------
// next_pc_mux
// Purely combinational selection of the next fetch address.
// Ports:
//   i_pc_sel        - select code (inc / branch / jump / return)
//   i_pc_plus1      - sequential successor of the current pc
//   i_branch_target - branch destination word address
//   i_jump_target   - jump destination word address
//   i_ret_addr      - return destination word address
//   o_next_pc       - selected next fetch address
// ---------------------------------------------------------------------------
module next_pc_mux
    import fetch_unit_pkg::*;
(
    input  logic [1:0]  i_pc_sel,
    input  logic [31:0] i_pc_plus1,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic [31:0] i_ret_addr,
    output logic [31:0] o_next_pc
);

    // Straight four-way select; every code is defined so no fallback is needed
    // beyond the default that keeps the block latch-free.
    always_comb begin
        o_next_pc = i_pc_plus1;
        case (i_pc_sel)
            PC_SEL_INC:    o_next_pc = i_pc_plus1;
            PC_SEL_BRANCH: o_next_pc = i_branch_target;
            PC_SEL_JUMP:   o_next_pc = i_jump_target;
            PC_SEL_RET:    o_next_pc = i_ret_addr;
            default:       o_next_pc = i_pc_plus1;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. A one-cycle if_en strobe launches a fetch: the
// address (RESET_PC for the first fetch after reset, otherwise the next-PC
// mux output) is registered onto imem_addr and a request is held until
// imem_ack, at which point the word is captured into ir.
// Ports:
//   clock, reset_n          - clock and asynchronous active-low reset
//   if_en                   - fetch strobe
//   pc_sel                  - next-PC select code
//   branch_target, jump_target, ret_addr - candidate next-PC addresses
//   imem_req, imem_addr     - instruction memory request and word address
//   imem_ack, imem_rdata    - memory response and instruction word
//   pc, pc_plus1            - address of the word in ir, and its successor
//   ir, func, ins_type      - instruction register and its decoded fields
//   busy, ir_valid, overrun - fetch outstanding, ir valid, sticky overrun
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_en,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] ret_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic [31:0] ir,
    output logic [4:0]  func,
    output logic [1:0]  ins_type,
    output logic        busy,
    output logic        ir_valid,
    output logic        overrun
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_imem_addr;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_overrun;
    logic        r_first;

    logic [31:0] w_pc_plus1;
    logic [31:0] w_mux_pc;
    logic [31:0] w_fetch_addr;
    logic        w_launch;
    logic        w_accept;
    logic        w_imem_req;
    logic        w_busy;

    // Successor address wraps naturally at 2^32 through 32-bit truncation.
    assign w_pc_plus1 = r_pc + 32'd1;

    next_pc_mux u_next_pc_mux (
        .i_pc_sel        (pc_sel),
        .i_pc_plus1      (w_pc_plus1),
        .i_branch_target (branch_target),
        .i_jump_target   (jump_target),
        .i_ret_addr      (ret_addr),
        .o_next_pc       (w_mux_pc)
    );

    // The very first fetch after reset ignores pc_sel and starts at RESET_PC.
    assign w_fetch_addr = r_first ? RESET_PC : w_mux_pc;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode. A strobe arriving while a request is
    // open is not a fetch (it only raises overrun in the datapath block), and
    // an ack seen while idle is simply not decoded.
    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_busy       = 1'b0;
        w_launch     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_en) begin
                    w_launch     = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                w_imem_req = 1'b1;
                w_busy     = 1'b1;
                if (imem_ack) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. imem_addr is captured at launch so it stays stable
    // for the whole request; ir_valid drops at launch and returns when the
    // word lands, and pc takes the address that produced that word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_imem_addr <= RESET_PC;
            r_pc        <= RESET_PC;
            r_ir        <= 32'd0;
            r_ir_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_first     <= 1'b1;
        end else begin
            if (w_launch) begin
                r_imem_addr <= w_fetch_addr;
                r_first     <= 1'b0;
                r_ir_valid  <= 1'b0;
            end
            if (w_accept) begin
                r_ir       <= imem_rdata;
                r_pc       <= r_imem_addr;
                r_ir_valid <= 1'b1;
            end
            if (if_en && (r_state == ST_REQ)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign imem_req  = w_imem_req;
    assign busy      = w_busy;
    assign imem_addr = r_imem_addr;
    assign pc        = r_pc;
    assign pc_plus1  = w_pc_plus1;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign overrun   = r_overrun;
    assign func      = r_ir[FUNC_MSB:FUNC_LSB];
    assign ins_type  = r_ir[TYPE_MSB:TYPE_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed plus randomized bench for fetch_unit. A small behavioural model
// (expected pc, ir, valid/overrun flags, first-fetch flag) predicts every
// observed value. Inputs change on the falling edge; outputs are sampled
// on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset_n;
    logic        if_en;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] ret_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] ir;
    logic [4:0]  func;
    logic [1:0]  ins_type;
    logic        busy;
    logic        ir_valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          mFirst;
    logic [31:0] mPc;
    logic [31:0] mIr;
    logic        mValid;
    logic        mOverrun;

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .if_en         (if_en),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .ret_addr      (ret_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .ir            (ir),
        .func          (func),
        .ins_type      (ins_type),
        .busy          (busy),
        .ir_valid      (ir_valid),
        .overrun       (overrun)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of a power-on / mid-operation reset.
    task automatic modelReset();
        mFirst   = 1'b1;
        mPc      = TB_RESET_PC;
        mIr      = 32'd0;
        mValid   = 1'b0;
        mOverrun = 1'b0;
    endtask

    // Everything that must hold whenever the unit is idle.
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_req"},      imem_req, 32'd0);
        checkOutput({tag, "_busy"},     busy,     32'd0);
        checkOutput({tag, "_pc"},       pc,       mPc);
        checkOutput({tag, "_pcp1"},     pc_plus1, mPc + 32'd1);
        checkOutput({tag, "_ir"},       ir,       mIr);
        checkOutput({tag, "_func"},     func,     mIr >> 27);
        checkOutput({tag, "_type"},     ins_type, (mIr >> 1) & 32'd3);
        checkOutput({tag, "_valid"},    ir_valid, mValid);
        checkOutput({tag, "_overrun"},  overrun,  mOverrun);
    endtask

    // One complete fetch: strobe, expected request address, ack after
    // 'delay' low cycles, then the resulting architectural state. With
    // 'ovr' set a second strobe is issued while the request is open.
    task automatic applyStimulus(input logic [1:0] sel, input int delay,
                                 input logic [31:0] data, input bit ovr, input string tag);
        logic [31:0] expAddr;
        int busyCycles;
        if (mFirst) begin
            expAddr = TB_RESET_PC;
        end else begin
            case (sel)
                2'd0:    expAddr = mPc + 32'd1;
                2'd1:    expAddr = branch_target;
                2'd2:    expAddr = jump_target;
                default: expAddr = ret_addr;
            endcase
        end
        @(negedge clock);
        if_en  = 1'b1;
        pc_sel = sel;
        @(negedge clock);
        if_en = 1'b0;
        checkOutput({tag, "_addr"},  imem_addr, expAddr);
        checkOutput({tag, "_req"},   imem_req,  32'd1);
        checkOutput({tag, "_vlow"},  ir_valid,  32'd0);
        busyCycles = 0;
        for (int i = 0; i <= delay; i++) begin
            if (busy) busyCycles++;
            if_en      = (ovr && i == 0 && delay > 0);
            imem_ack   = (i == delay);
            imem_rdata = (i == delay) ? data : $urandom;
            if (ovr && i == 0 && delay > 0) mOverrun = 1'b1;
            @(negedge clock);
            if_en = 1'b0;
            if (i < delay) begin
                checkOutput({tag, "_irhold"},  ir,       mIr);
                checkOutput({tag, "_vhold"},   ir_valid, 32'd0);
                checkOutput({tag, "_addrhold"}, imem_addr, expAddr);
            end
        end
        imem_ack = 1'b0;
        mFirst   = 1'b0;
        mPc      = expAddr;
        mIr      = data;
        mValid   = 1'b1;
        checkOutput({tag, "_busycnt"}, busyCycles, delay + 1);
        checkIdle(tag);
    endtask

    initial begin
        reset_n       = 1'b0;
        if_en         = 1'b0;
        pc_sel        = 2'b00;
        branch_target = 32'd0;
        jump_target   = 32'd0;
        ret_addr      = 32'd0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        modelReset();

        // Reset values.
        repeat (2) @(negedge clock);
        checkOutput("rst_addr", imem_addr, TB_RESET_PC);
        checkIdle("rst");
        reset_n = 1'b1;
        @(negedge clock);
        checkIdle("rst_rel");

        // First fetch from RESET_PC with an immediate ack (func 00010, type 10).
        applyStimulus(2'b00, 0, 32'h1000_0004, 1'b0, "first");
        checkOutput("first_func_lit", func, 32'h2);
        checkOutput("first_type_lit", ins_type, 32'h2);

        // Each select code in turn.
        applyStimulus(2'b00, 0, $urandom, 1'b0, "seq");
        branch_target = 32'h40;
        applyStimulus(2'b01, 0, $urandom, 1'b0, "branch");
        ret_addr = 32'd7;
        applyStimulus(2'b11, 0, $urandom, 1'b0, "ret");

        // Slow memory: ack after three low cycles.
        applyStimulus(2'b00, 3, $urandom, 1'b0, "slow");

        // An ack while idle must not disturb ir.
        @(negedge clock);
        imem_ack   = 1'b1;
        imem_rdata = ~mIr;
        @(negedge clock);
        imem_ack = 1'b0;
        checkIdle("idleack");

        // Randomized fetches.
        for (int n = 0; n < 8; n++) begin
            branch_target = $urandom;
            jump_target   = $urandom;
            ret_addr      = $urandom;
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom, 1'b0, "rand");
        end

        // Strobe during an open request: sticky overrun, no extra request.
        applyStimulus(2'b00, 2, $urandom, 1'b1, "ovr");
        @(negedge clock);
        checkOutput("ovr_noreq", imem_req, 32'd0);
        branch_target = $urandom;
        applyStimulus(2'b01, 1, $urandom, 1'b0, "ovr_hold");

        // pc at the top of the address space wraps to zero.
        jump_target = 32'hFFFF_FFFF;
        applyStimulus(2'b10, 0, $urandom, 1'b0, "top");
        checkOutput("top_pcp1_zero", pc_plus1, 32'd0);
        applyStimulus(2'b00, 0, $urandom, 1'b0, "wrap");
        checkOutput("wrap_pc_zero", pc, 32'd0);

        // Reset while a request is open, followed by a late ack.
        @(negedge clock);
        if_en  = 1'b1;
        pc_sel = 2'b00;
        @(negedge clock);
        if_en = 1'b0;
        checkOutput("midrst_req_open", imem_req, 32'd1);
        #2 reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_addr", imem_addr, TB_RESET_PC);
        checkIdle("midrst_async");
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        checkIdle("midrst_lateack");

        // After reset the next fetch is again from RESET_PC.
        ret_addr = $urandom;
        applyStimulus(2'b11, 1, $urandom, 1'b0, "refirst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, word address of the first instruction fetched after reset.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_en  input  1  one-cycle fetch strobe from the stage sequencer.
REQ-005 SHALL have port pc_sel  input  2  next-PC select: 00 pc+1, 01 branch_target, 10 jump_target, 11 ret_addr.
REQ-006 SHALL have ports branch_target, jump_target, ret_addr  input  32 each  candidate next-PC word addresses.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request.
REQ-008 SHALL have port imem_addr  output  32  word address, stable while imem_req is high.
REQ-009 SHALL have port imem_ack  input  1  memory data valid; may assert in the first request cycle.
REQ-010 SHALL have port imem_rdata  input  32  instruction word, sampled when imem_ack is high.
REQ-011 SHALL have ports pc  output  32 and pc_plus1  output  32  address of the instruction held in ir, and pc+1.
REQ-012 SHALL have ports ir  output  32, func  output  5 (= ir[31:27]), ins_type  output  2 (= ir[2:1]).
REQ-013 SHALL have ports busy  output  1 (fetch outstanding), ir_valid  output  1, overrun  output  1 (sticky error).

Function
REQ-014 SHALL implement FSM states IDLE, REQ.
REQ-015 IDLE with if_en: SHALL compute fetch address (RESET_PC if first fetch since reset, otherwise pc_sel mux), register it to imem_addr, enter REQ next cycle.
REQ-016 REQ: imem_req and busy SHALL be 1; on imem_ack SHALL load ir<=imem_rdata, pc<=imem_addr, ir_valid<=1, return to IDLE.
REQ-017 Fetch latency SHALL be 2 cycles from if_en edge to ir update when imem_ack is high in the first REQ cycle; each extra ack-low cycle adds one.
REQ-018 pc_plus1 SHALL wrap modulo 2^32 (32'hFFFF_FFFF -> 0).
REQ-019 if_en while in REQ SHALL be ignored for fetching and SHALL set overrun to 1 until reset.
REQ-020 ir_valid SHALL fall to 0 on the cycle a new fetch enters REQ and rise when ir is reloaded.
REQ-021 imem_ack in IDLE SHALL be ignored.
REQ-022 func and ins_type SHALL be combinational slices of registered ir (no added latency).

Reset
REQ-023 reset_n low SHALL asynchronously force: state IDLE, imem_req 0, imem_addr RESET_PC, pc RESET_PC, ir 0, ir_valid 0, busy 0, overrun 0, first-fetch flag 1.
REQ-024 reset mid-REQ SHALL abandon the request; a later imem_ack SHALL not load ir.

Structure
REQ-025 Shared package SHALL hold FSM state encoding, pc_sel codes, and field positions FUNC_MSB/LSB, TYPE_MSB/LSB.
REQ-026 Next-PC mux SHALL be sub-module next_pc_mux (combinational); rest flat.

Verification
REQ-027 Reset release, if_en pulse, ack immediate, rdata 32'h1000_0004 -> imem_addr 0, ir 32'h1000_0004, func 5'b00010, ins_type 2'b10, pc 0 two cycles after if_en.
REQ-028 Second if_en with pc_sel 00 -> imem_addr 1; pc_sel 01, branch_target 32'h40 -> imem_addr 32'h40; pc_sel 11, ret_addr 7 -> imem_addr 7.
REQ-029 Ack delayed 3 cycles -> busy high 4 cycles, ir unchanged until ack edge, ir_valid low meanwhile.
REQ-030 if_en during REQ -> overrun 1, no second request, overrun held through later fetches until reset_n low.
REQ-031 pc 32'hFFFF_FFFF, pc_sel 00 -> imem_addr 0, pc_plus1 0 while pc is FFFF_FFFF.
REQ-032 reset_n low mid-REQ then ack -> all outputs at reset values, ir stays 0.
